// File: rtl/fft_ctrl_pkg.sv
// Shared state encoding, point-count limits and Avalon-ST error codes for the FFT sink framing controller.
package fft_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [15:0] MIN_PTS = 16'd8;
  localparam logic [15:0] MAX_PTS = 16'd1024;

  localparam logic [1:0] AVST_ERR_NONE           = 2'b00;
  localparam logic [1:0] AVST_ERR_MISSING_SOP    = 2'b01;
  localparam logic [1:0] AVST_ERR_MISSING_EOP    = 2'b10;
  localparam logic [1:0] AVST_ERR_UNEXPECTED_EOP = 2'b11;

  // Power of two within MIN_PTS..MAX_PTS; a zero count fails the lower bound.
  function automatic logic pts_valid(input logic [15:0] pts);
    return (pts >= MIN_PTS) && (pts <= MAX_PTS) && ((pts & (pts - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer: head is valid the cycle after a push, no extra read latency.
// Pushes while full and pops while empty are ignored; flush empties it synchronously.
module sample_fifo #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit tells full apart from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames a free-running ADC stream into Avalon-ST sop/eop beats for the FFT sink; sample-to-valid is two edges.
// sink_ready stalls the output register, the FIFO absorbs up to FIFO_DEPTH samples, and further samples are dropped and flagged.
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int PTS_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic              cfg_inverse,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_ovf,
  input  logic              sink_ready,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [1:0]        sink_error,
  output logic              inverse,
  output logic [PTS_W-1:0]  fft_pts,
  output logic              busy,
  output logic              cfg_err,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  state_t            state;
  logic [PTS_W-1:0]  idx;
  logic              stop_pending;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              cfg_ok;
  logic              xfer;
  logic              eop_xfer;
  logic              stop_req;
  logic              go_idle;
  logic              push;
  logic              drop;
  logic              load;
  logic              pop;
  logic              flush;
  logic [PTS_W-1:0]  nxt_idx;
  logic [PTS_W-1:0]  nxt_pts;

  assign sink_imag  = '0;
  assign sink_error = AVST_ERR_NONE;
  assign busy       = (state == STREAM);

  always_comb begin
    cfg_ok   = pts_valid(16'(cfg_pts));
    xfer     = sink_valid && sink_ready;
    eop_xfer = xfer && sink_eop;
    stop_req = stop_pending || stop;
    go_idle  = (state == STREAM) && stop_req && (eop_xfer || ((idx == '0) && !sink_valid));
    push     = (state == STREAM) && adc_valid && !fifo_full;
    drop     = (state == STREAM) && adc_valid && fifo_full;
    load     = (state == STREAM) && !go_idle && (!sink_valid || xfer);
    pop      = load && !fifo_empty;
    flush    = (state == IDLE) || go_idle;
    // Index and length of the beat loaded this edge; a new frame already sees a re-latched length.
    nxt_idx  = xfer ? (sink_eop ? '0 : idx + 1'b1) : idx;
    nxt_pts  = (eop_xfer && cfg_ok) ? cfg_pts : fft_pts;
  end

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (adc_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      stop_pending <= 1'b0;
      sink_valid   <= 1'b0;
      sink_sop     <= 1'b0;
      sink_eop     <= 1'b0;
      sink_real    <= '0;
      inverse      <= 1'b0;
      fft_pts      <= PTS_W'(MAX_PTS);
      cfg_err      <= 1'b0;
      overflow     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_ok) begin
              fft_pts <= cfg_pts;
              inverse <= cfg_inverse;
              idx     <= '0;
              state   <= STREAM;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (stop) stop_pending <= 1'b1;
          if (xfer) idx <= nxt_idx;
          if (eop_xfer) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (cfg_ok) begin
              fft_pts <= cfg_pts;
              inverse <= cfg_inverse;
            end else begin
              cfg_err <= 1'b1;
            end
          end
          if (go_idle) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            idx          <= '0;
            sink_valid   <= 1'b0;
            sink_sop     <= 1'b0;
            sink_eop     <= 1'b0;
            sink_real    <= '0;
          end else if (load) begin
            sink_valid <= !fifo_empty;
            sink_sop   <= !fifo_empty && (nxt_idx == '0);
            sink_eop   <= !fifo_empty && (nxt_idx == nxt_pts - 1'b1);
            if (!fifo_empty) sink_real <= fifo_head;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
